// File: rtl/dot_product_pkg.sv
// Shared sizing helpers and result type for the streaming sigma*J dot product.
// The result width must cover +/-VECTOR_SIZE*(2^J_EW-1).
package dot_product_pkg;

    localparam int DEF_VECTOR_SIZE     = 256;
    localparam int DEF_CHUNK_SIZE      = 64;
    localparam int DEF_J_ELEMENT_WIDTH = 4;

    function automatic int calc_res_w(input int vector_size, input int j_ew);
        return j_ew + $clog2(vector_size) + 1;
    endfunction

    function automatic int calc_num_beats(input int vector_size, input int chunk_size);
        return vector_size / chunk_size;
    endfunction

    // A single-beat column still needs a one-bit counter.
    function automatic int calc_beat_cnt_w(input int num_beats);
        return (num_beats > 1) ? $clog2(num_beats) : 1;
    endfunction

    localparam int DOT_RES_W      = calc_res_w(DEF_VECTOR_SIZE, DEF_J_ELEMENT_WIDTH);
    localparam int DOT_NUM_BEATS  = calc_num_beats(DEF_VECTOR_SIZE, DEF_CHUNK_SIZE);
    localparam int DOT_BEAT_CNT_W = calc_beat_cnt_w(DOT_NUM_BEATS);

    typedef logic signed [DOT_RES_W-1:0] dot_res_t;

endpackage

// File: rtl/dot_product_stream_if.sv
// Chunk-input and result-output handshake bundle of dot_product_stream.
interface dot_product_stream_if #(
    parameter int CHUNK_SIZE      = 64,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int RES_W           = 13
);
    // Both channels: a transfer happens on a rising edge where valid & ready are 1.
    // A producer holds valid and its payload stable until that edge; ready may be
    // derived combinationally from the consumer state but never from valid itself.
    logic                                  in_valid_i;
    logic                                  in_ready_o;
    logic [CHUNK_SIZE-1:0]                 in_sigma_i;
    logic [CHUNK_SIZE*J_ELEMENT_WIDTH-1:0] in_j_i;
    logic                                  out_valid_o;
    logic                                  out_ready_i;
    logic signed [RES_W-1:0]               out_dot_o;
    logic                                  busy_o;

    modport slave (
        input  in_valid_i, in_sigma_i, in_j_i, out_ready_i,
        output in_ready_o, out_valid_o, out_dot_o, busy_o
    );

    modport master (
        output in_valid_i, in_sigma_i, in_j_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_dot_o, busy_o
    );

endinterface

// File: rtl/dot_chunk_tree.sv
// Combinational signed adder tree: sum of +/-J over one CHUNK_SIZE beat.
// DOTPROD_SIGNED_J_EN selects two's-complement J elements instead of unsigned.
module dot_chunk_tree
    import dot_product_pkg::*;
#(
    parameter int VECTOR_SIZE     = 256,
    parameter int CHUNK_SIZE      = 64,
    parameter int J_ELEMENT_WIDTH = 4,
    localparam int RES_W          = calc_res_w(VECTOR_SIZE, J_ELEMENT_WIDTH)
) (
    input  logic [CHUNK_SIZE-1:0]                 sigma,
    input  logic [CHUNK_SIZE*J_ELEMENT_WIDTH-1:0] j,
    output logic signed [RES_W-1:0]               sum
);

    logic [J_ELEMENT_WIDTH-1:0] elem;
    logic signed [RES_W-1:0]    ext;
    logic signed [RES_W-1:0]    node [CHUNK_SIZE];

    always_comb begin
        elem = '0;
        ext  = '0;
        for (int k = 0; k < CHUNK_SIZE; k++) begin
            elem = j[k*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH];
`ifdef DOTPROD_SIGNED_J_EN
            ext = RES_W'($signed(elem));
`else
            ext = RES_W'(elem);
`endif
            node[k] = sigma[k] ? ext : -ext;
        end
        // Pairwise reduction in place; each level halves the live width.
        for (int w = CHUNK_SIZE / 2; w > 0; w = w / 2) begin
            for (int k = 0; k < w; k++) begin
                node[k] = node[2*k] + node[2*k+1];
            end
        end
        sum = node[0];
    end

endmodule

// File: rtl/dot_product_stream.sv
// Streaming sigma*J column dot product: chunk tree, S1 register, accumulator, result hold.
// Honours DOTPROD_SIGNED_J_EN through dot_chunk_tree (signed J elements when defined).
module dot_product_stream
    import dot_product_pkg::*;
#(
    parameter int VECTOR_SIZE     = 256,
    parameter int CHUNK_SIZE      = 64,
    parameter int J_ELEMENT_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dot_product_stream_if.slave   bus
);

    localparam int NUM_BEATS = calc_num_beats(VECTOR_SIZE, CHUNK_SIZE);
    localparam int RES_W     = calc_res_w(VECTOR_SIZE, J_ELEMENT_WIDTH);
    localparam int BEAT_W    = calc_beat_cnt_w(NUM_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    logic signed [RES_W-1:0] chunk_sum;
    logic                    adv;
    logic                    fire;
    logic [BEAT_W-1:0]       beat_cnt;
    logic                    s1_valid;
    logic signed [RES_W-1:0] s1_sum;
    logic                    s1_first;
    logic                    s1_last;
    logic signed [RES_W-1:0] acc;
    logic signed [RES_W-1:0] acc_next;
    logic                    out_valid_q;
    logic signed [RES_W-1:0] out_dot_q;

    dot_chunk_tree #(
        .VECTOR_SIZE     (VECTOR_SIZE),
        .CHUNK_SIZE      (CHUNK_SIZE),
        .J_ELEMENT_WIDTH (J_ELEMENT_WIDTH)
    ) u_tree (
        .sigma (bus.in_sigma_i),
        .j     (bus.in_j_i),
        .sum   (chunk_sum)
    );

    // The whole pipe moves together; a held result freezes every stage.
    assign adv      = ~out_valid_q | bus.out_ready_i;
    assign fire     = bus.in_valid_i & adv;
    assign acc_next = (s1_first ? '0 : acc) + s1_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt    <= '0;
            s1_valid    <= 1'b0;
            s1_sum      <= '0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_dot_q   <= '0;
        end else if (adv) begin
            s1_valid <= fire;
            s1_sum   <= chunk_sum;
            s1_first <= (beat_cnt == '0);
            s1_last  <= (beat_cnt == LAST_BEAT);
            if (fire) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
            if (s1_valid) begin
                acc <= acc_next;
            end
            // A landing result overwrites one being consumed this same edge.
            if (s1_valid && s1_last) begin
                out_dot_q   <= acc_next;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o  = adv;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_dot_o   = out_dot_q;
    assign bus.busy_o      = (beat_cnt != '0) | s1_valid;

endmodule

// File: tb/tb_dot_product_stream.sv
// Self-checking bench for dot_product_stream against a whole-column arithmetic model.
module tb_dot_product_stream;
  import dot_product_pkg::*;

  localparam int VS  = 256;
  localparam int CS  = 64;
  localparam int JEW = 4;
  localparam int NB  = VS / CS;
  localparam int RW  = calc_res_w(VS, JEW);
  localparam int RANDOM_COLUMNS = 2000;

  typedef logic [VS-1:0]     sig_col_t;
  typedef logic [VS*JEW-1:0] j_col_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_product_stream_if #(.CHUNK_SIZE(CS), .J_ELEMENT_WIDTH(JEW), .RES_W(RW)) dif ();

  dot_product_stream #(
    .VECTOR_SIZE     (VS),
    .CHUNK_SIZE      (CS),
    .J_ELEMENT_WIDTH (JEW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (dif)
  );

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  logic          obs_valid;
  logic          obs_in_ready;
  logic          obs_busy;
  logic [RW-1:0] obs_dot;

  // Reference model: whole-column sum with plain integer arithmetic.
  function automatic logic [RW-1:0] model_dot(input sig_col_t s, input j_col_t j);
    int sum;
    int e;
    sum = 0;
    for (int i = 0; i < VS; i++) begin
      e = int'(j[i*JEW +: JEW]);
`ifdef DOTPROD_SIGNED_J_EN
      if (e >= (1 << (JEW - 1))) e = e - (1 << JEW);
`endif
      sum = s[i] ? sum + e : sum - e;
    end
    return RW'(sum);
  endfunction

  function automatic j_col_t j_mod16();
    j_col_t j;
    for (int i = 0; i < VS; i++) j[i*JEW +: JEW] = JEW'(i % 16);
    return j;
  endfunction

  function automatic j_col_t j_const(input logic [JEW-1:0] v);
    j_col_t j;
    for (int i = 0; i < VS; i++) j[i*JEW +: JEW] = v;
    return j;
  endfunction

  function automatic sig_col_t sig_odd();
    sig_col_t s;
    for (int i = 0; i < VS; i++) s[i] = (i % 2 == 1);
    return s;
  endfunction

  // Clock/driver: drive at negedge, observe 1 time unit later, collect consumed results.
  task automatic cycle(input logic v, input logic [CS-1:0] s, input logic [CS*JEW-1:0] j,
                       input logic rdy, output logic fired);
    @(negedge clk);
    dif.in_valid_i  = v;
    dif.in_sigma_i  = s;
    dif.in_j_i      = j;
    dif.out_ready_i = rdy;
    #1;
    obs_valid    = dif.out_valid_o;
    obs_dot      = dif.out_dot_o;
    obs_in_ready = dif.in_ready_o;
    obs_busy     = dif.busy_o;
    fired = v & obs_in_ready;
    if (obs_valid && rdy) got_q.push_back(obs_dot);
  endtask

  task automatic idle(input logic rdy);
    logic f;
    cycle(1'b0, '0, '0, rdy, f);
  endtask

  function automatic logic rnd_pct(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic send_column(input sig_col_t s, input j_col_t j, input int gap_pct, input int rdy_pct);
    logic fired;
    int tries;
    for (int b = 0; b < NB; b++) begin
      for (int g = 0; g < 3 && rnd_pct(gap_pct); g++) idle(rnd_pct(rdy_pct));
      fired = 1'b0;
      tries = 0;
      while (!fired && tries < 200) begin
        cycle(1'b1, s[b*CS +: CS], j[b*CS*JEW +: CS*JEW], rnd_pct(rdy_pct), fired);
        tries++;
      end
      if (!fired) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout: beat %0d not accepted after %0d cycles, required acceptance", b, tries);
      end
    end
  endtask

  task automatic drain(input int n, input int rdy_pct);
    int tries;
    tries = 0;
    while (got_q.size() < n && tries < 500) begin
      idle(rnd_pct(rdy_pct));
      tries++;
    end
  endtask

  task automatic test_reset();
    dif.in_valid_i  = 1'b0;
    dif.in_sigma_i  = '0;
    dif.in_j_i      = '0;
    dif.out_ready_i = 1'b0;
    rst = 1'b1;
    repeat (3) idle(1'b0);
    rst = 1'b0;
    idle(1'b0);
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", obs_in_ready); end
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", obs_valid); end
    checks++; if (obs_dot !== '0) begin errors++; $display("FAIL reset_out_dot: got %0d expected 0", $signed(obs_dot)); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", obs_busy); end
  endtask

  task automatic test_basic();
    logic f;
    j_col_t j;
    sig_col_t s;
    logic [RW-1:0] e;
    j = j_mod16();
    s = '1;
    got_q.delete();
    for (int b = 0; b < NB; b++) begin
      cycle(1'b1, s[b*CS +: CS], j[b*CS*JEW +: CS*JEW], 1'b1, f);
      checks++; if (f !== 1'b1) begin errors++; $display("FAIL basic_beat_accept: beat %0d got %b expected 1", b, f); end
    end
    idle(1'b1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got valid %b expected 0", obs_valid); end
    idle(1'b1);
    e = RW'(1920);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got valid %b expected 1", obs_valid); end
    checks++; if (obs_dot !== e) begin errors++; $display("FAIL basic_sum_plus: got %0d expected %0d", $signed(obs_dot), $signed(e)); end
    idle(1'b1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got valid %b expected 0", obs_valid); end
    got_q.delete();
    send_column('0, j, 0, 100);
    drain(1, 100);
    e = RW'(-1920);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL basic_minus_count: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== e) begin errors++; $display("FAIL basic_sum_minus: got %0d expected %0d", $signed(got_q[0]), $signed(e)); end
    end
  endtask

  task automatic test_back_to_back();
    sig_col_t cs_q[3];
    logic [RW-1:0] ev[3];
    int vcyc[$];
    logic [RW-1:0] vdot[$];
    logic f;
    j_col_t j;
    int t;
    j = j_mod16();
    cs_q[0] = '1;        ev[0] = RW'(1920);
    cs_q[1] = sig_odd(); ev[1] = RW'(128);
    cs_q[2] = '0;        ev[2] = RW'(-1920);
    t = 0;
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < NB; b++) begin
        cycle(1'b1, cs_q[c][b*CS +: CS], j[b*CS*JEW +: CS*JEW], 1'b1, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL b2b_no_stall: col %0d beat %0d got %b expected 1", c, b, f); end
        if (obs_valid) begin vcyc.push_back(t); vdot.push_back(obs_dot); end
        t++;
      end
    end
    repeat (4) begin
      idle(1'b1);
      if (obs_valid) begin vcyc.push_back(t); vdot.push_back(obs_dot); end
      t++;
    end
    checks++; if (vcyc.size() !== 3) begin errors++; $display("FAIL b2b_result_count: got %0d expected 3", vcyc.size()); end
    else begin
      for (int c = 0; c < 3; c++) begin
        checks++; if (vcyc[c] !== 5 + 4*c) begin errors++; $display("FAIL b2b_result_cycle: col %0d got %0d expected %0d", c, vcyc[c], 5 + 4*c); end
        checks++; if (vdot[c] !== ev[c]) begin errors++; $display("FAIL b2b_result_value: col %0d got %0d expected %0d", c, $signed(vdot[c]), $signed(ev[c])); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic f;
    j_col_t ja, jb;
    int tries;
    ja = j_mod16();
    jb = j_const(4'hF);
    got_q.delete();
    send_column('1, ja, 0, 100);
    tries = 0;
    do begin idle(1'b0); tries++; end while (!obs_valid && tries < 5);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL bp_result_present: got valid %b expected 1", obs_valid); end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, '1, jb[0 +: CS*JEW], 1'b0, f);
      checks++; if (f !== 1'b0 || obs_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got ready %b fired %b expected 0", k, obs_in_ready, f); end
      checks++; if (obs_valid !== 1'b1 || obs_dot !== RW'(1920)) begin errors++; $display("FAIL bp_hold: cycle %0d got valid %b dot %0d expected 1 / 1920", k, obs_valid, $signed(obs_dot)); end
    end
    send_column('1, jb, 0, 100);
    drain(2, 100);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL bp_count: got %0d expected 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== RW'(1920)) begin errors++; $display("FAIL bp_first: got %0d expected 1920", $signed(got_q[0])); end
      checks++; if (got_q[1] !== RW'(3840)) begin errors++; $display("FAIL bp_next_column: got %0d expected 3840", $signed(got_q[1])); end
    end
  endtask

  task automatic test_mid_reset();
    logic f;
    j_col_t j;
    j = j_const(4'hF);
    got_q.delete();
    for (int b = 0; b < 2; b++) cycle(1'b1, '1, j[b*CS*JEW +: CS*JEW], 1'b1, f);
    rst = 1'b1;
    idle(1'b1);
    idle(1'b1);
    rst = 1'b0;
    idle(1'b1);
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", obs_busy); end
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", obs_valid); end
    got_q.delete();
    send_column('0, j, 0, 100);
    repeat (8) idle(1'b1);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_reset_pulses: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== RW'(-3840)) begin errors++; $display("FAIL mid_reset_sum: got %0d expected -3840", $signed(got_q[0])); end
    end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle_busy: got %b expected 0", obs_busy); end
  endtask

  task automatic test_signed_j();
    logic [RW-1:0] e;
`ifdef DOTPROD_SIGNED_J_EN
    e = RW'(-256);
`else
    e = RW'(3840);
`endif
    got_q.delete();
    send_column('1, j_const(4'hF), 0, 100);
    repeat (4) idle(1'b1);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL signed_j_count: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== e) begin errors++; $display("FAIL signed_j_sum: got %0d expected %0d", $signed(got_q[0]), $signed(e)); end
    end
  endtask

  task automatic test_random();
    sig_col_t s;
    j_col_t j;
    int n;
    exp_q.delete();
    got_q.delete();
    for (int c = 0; c < RANDOM_COLUMNS; c++) begin
      if ($urandom_range(7) == 0) begin
        s = $urandom_range(1) ? '1 : '0;
        j = j_const(JEW'($urandom_range(15)));
      end else begin
        for (int i = 0; i < VS; i++) begin
          s[i] = 1'($urandom_range(1));
          j[i*JEW +: JEW] = JEW'($urandom_range(15));
        end
      end
      exp_q.push_back(model_dot(s, j));
      send_column(s, j, 25, 70);
    end
    drain(RANDOM_COLUMNS, 70);
    repeat (6) idle(1'b1);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_result: column %0d got %0d expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_signed_j();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
